regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the pipelined ARM core's three-port register file.
- Provides NREAD combinational read ports and two write ports: port A for the ALU/writeback result, port B for base-register writeback, e.g. LDR post-index.
- Adds write-through bypass, reset clearing and a per-register pending scoreboard for hazard detection.
- Sits in the decode stage; writes arrive from the writeback stage; the R15 read value (PC+8) is supplied externally.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register address width; NREG = 2**ADDR_W registers.
- NREAD, 3, number of read ports (1..4).
- PC_IDX, 15, index of the PC register: reads return r15, writes are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ra  in  NREAD*ADDR_W  packed read addresses; port i = ra[i*ADDR_W +: ADDR_W].
- rd  out  NREAD*DATA_W  packed read data; port i = rd[i*DATA_W +: DATA_W].
- rdy  out  NREAD  rdy[i] = 1 when the register at ra[i] has no pending write.
- we_a  in  1  write enable, port A.
- wa_a  in  ADDR_W  write address, port A.
- wd_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, port B.
- wa_b  in  ADDR_W  write address, port B.
- wd_b  in  DATA_W  write data, port B.
- r15  in  DATA_W  PC+8 value, returned for reads of PC_IDX.
- iss_vld  in  1  issue strobe: mark register iss_addr pending.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- any_pend  out  1  OR of all pending bits, used for drain/flush.

Behaviour:
- Reset (async, active-high):
  - All NREG registers cleared to 0.
  - All pending bits cleared.
  - any_pend = 0.
  - Register contents are lost even when reset is asserted mid-operation; writes presented during reset are dropped.
- Writes:
  - On the rising clk edge, when we_x = 1 and wa_x != PC_IDX, rf[wa_x] <= wd_x.
  - Writes to PC_IDX are silently dropped.
  - When we_a and we_b both target the same address, port A wins and port B is dropped.
- Reads (combinational, per port i), in priority order:
  1. ra[i] == PC_IDX: rd = r15.
  2. we_a && wa_a == ra[i]: rd = wd_a (same-cycle bypass).
  3. we_b && wa_b == ra[i]: rd = wd_b.
  4. Otherwise: rd = rf[ra[i]].
  - The bypass gives zero-cycle write-to-read visibility, replacing the earlier negedge-write scheme.
- Scoreboard (pending bit per register):
  - Set on the rising edge when iss_vld = 1 and iss_addr != PC_IDX.
  - Cleared on the rising edge by any enabled write to that address (port A or B).
  - When a set and a clear hit the same register in the same cycle, set wins: the new instruction's result is still outstanding.
- rdy[i]:
  - 1 when ra[i] == PC_IDX.
  - 1 when a write to ra[i] is active this cycle (consistent with the bypass).
  - Otherwise rdy[i] = ~pend[ra[i]].
- any_pend = |pend (registered bits only, no bypass term).
- Latency: reads 0 cycles; a write is visible in rf at the next edge; a pending bit is visible on rdy the cycle after iss_vld.
- No flow control: the block never stalls; the hazard unit consumes rdy.

Optional Feature:
- Macro: REGFILE_BANKED_EN.
- When defined:
  - Adds input irq_mode (1 bit) and a second bank of R13/R14 (SP_irq, LR_irq).
  - While irq_mode = 1, reads, writes, bypass and pending bits for addresses 13/14 use the IRQ bank.
  - Bypass compares the bank as well as the address.
  - Reset clears both banks.
  - irq_mode is sampled combinationally, so switching takes effect the same cycle.
- When undefined: no irq_mode port, single bank, behaviour exactly as above.

Test Plan:
- Reset check: assert reset mid-cycle after writing rf[3] = 32'hDEADBEEF -> rd for ra = 3 reads 0 immediately; rdy = all 1s; any_pend = 0.
- Write port A: we_a = 1, wa_a = 5, wd_a = 32'h1234 -> port 0 with ra = 5 shows 32'h1234 in the same cycle (bypass) and after the edge with we_a = 0 (stored).
- Dual-write collision: both ports write addr 7, wd_a = 32'hA, wd_b = 32'hB -> rd = 32'hA on all ports; after the edge rf[7] = 32'hA.
- PC handling: we_a = 1, wa_a = 15, wd_a = 32'h0, r15 = 32'h108 -> ra = 15 returns 32'h108 before and after the edge; rdy = 1.
- Scoreboard: iss_vld with iss_addr = 2 -> next cycle rdy = 0 for ra = 2 and any_pend = 1. In the same cycle, a write to 2 with iss_vld for 2 -> pending stays set. A later write to 2 with no issue -> rdy = 1 and any_pend = 0.
- REGFILE_BANKED_EN: write R13 = 32'h100 with irq_mode = 0, then R13 = 32'h200 with irq_mode = 1 -> reads return 32'h100 / 32'h200 per mode.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending scoreboard (optional REGFILE_BANKED_EN)
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREAD  = 3,
  parameter int PC_IDX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  output logic [NREAD-1:0]        rdy,
  input  logic                    we_a,
  input  logic [ADDR_W-1:0]       wa_a,
  input  logic [DATA_W-1:0]       wd_a,
  input  logic                    we_b,
  input  logic [ADDR_W-1:0]       wa_b,
  input  logic [DATA_W-1:0]       wd_b,
  input  logic [DATA_W-1:0]       r15,
  input  logic                    iss_vld,
  input  logic [ADDR_W-1:0]       iss_addr,
`ifdef REGFILE_BANKED_EN
  input  logic                    irq_mode,
`endif
  output logic                    any_pend
);

  localparam int NREG = 1 << ADDR_W;
`ifdef REGFILE_BANKED_EN
  // Two extra physical slots hold the IRQ copies of R13/R14.
  localparam int NPHYS = NREG + 2;
  localparam int PW    = ADDR_W + 1;
`else
  localparam int NPHYS = NREG;
  localparam int PW    = ADDR_W;
`endif
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  // Map an architectural address to its physical slot; with banking the
  // bank is folded into the index so every compare also compares the bank.
  function automatic logic [PW-1:0] phys(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BANKED_EN
    if (irq_mode && a == ADDR_W'(13)) return PW'(NREG);
    if (irq_mode && a == ADDR_W'(14)) return PW'(NREG + 1);
`endif
    return PW'(a);
  endfunction

  logic [DATA_W-1:0] rf_q [NPHYS];
  logic [NPHYS-1:0]  pend_q;
  logic [NPHYS-1:0]  pend_d;

  logic [PW-1:0] pa;
  logic [PW-1:0] pb;
  logic [PW-1:0] pi;
  logic          wr_a;
  logic          wr_b;
  logic          clr_b;

  assign pa = phys(wa_a);
  assign pb = phys(wa_b);
  assign pi = phys(iss_addr);

  // PC writes are dropped; port A beats port B on a same-slot collision.
  assign wr_a  = we_a && (wa_a != PC_A);
  assign clr_b = we_b && (wa_b != PC_A);
  assign wr_b  = clr_b && !(wr_a && (pa == pb));

  // Read ports: PC, then port-A bypass, then port-B bypass, then storage.
  genvar g;
  generate
    for (g = 0; g < NREAD; g++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [PW-1:0]     p;
      logic              is_pc;
      logic              hit_a;
      logic              hit_b;

      assign a     = ra[g*ADDR_W +: ADDR_W];
      assign p     = phys(a);
      assign is_pc = (a == PC_A);
      assign hit_a = we_a && (pa == p);
      assign hit_b = we_b && (pb == p);

      assign rd[g*DATA_W +: DATA_W] = is_pc ? r15  :
                                      hit_a ? wd_a :
                                      hit_b ? wd_b : rf_q[p];
      // An in-flight write counts as ready, matching the data bypass.
      assign rdy[g] = is_pc | hit_a | hit_b | ~pend_q[p];
    end
  endgenerate

  // Pending next-state: writes clear, an issue sets afterwards so set wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_a)  pend_d[pa] = 1'b0;
    if (clr_b) pend_d[pb] = 1'b0;
    if (iss_vld && (iss_addr != PC_A)) pend_d[pi] = 1'b1;
  end

  // Register storage; async reset wipes every slot in both banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NPHYS; k++) rf_q[k] <= '0;
    end else begin
      if (wr_a) rf_q[pa] <= wd_a;
      if (wr_b) rf_q[pb] <= wd_b;
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign any_pend = |pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven scoreboard bench for regfile_sb
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ra;
  logic [95:0] rd;
  logic [2:0]  rdy;
  logic        we_a;
  logic [3:0]  wa_a;
  logic [31:0] wd_a;
  logic        we_b;
  logic [3:0]  wa_b;
  logic [31:0] wd_b;
  logic [31:0] r15;
  logic        iss_vld;
  logic [3:0]  iss_addr;
  logic        any_pend;
`ifdef REGFILE_BANKED_EN
  logic        irq_mode = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clk      (clk),
    .reset    (reset),
    .ra       (ra),
    .rd       (rd),
    .rdy      (rdy),
    .we_a     (we_a),
    .wa_a     (wa_a),
    .wd_a     (wd_a),
    .we_b     (we_b),
    .wa_b     (wa_b),
    .wd_b     (wd_b),
    .r15      (r15),
    .iss_vld  (iss_vld),
    .iss_addr (iss_addr),
`ifdef REGFILE_BANKED_EN
    .irq_mode (irq_mode),
`endif
    .any_pend (any_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ra;
    logic        we_a;
    logic [3:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [3:0]  wa_b;
    logic [31:0] wd_b;
    logic        iss;
    logic [3:0]  ia;
    logic [95:0] erd;
    logic [2:0]  erdy;
    logic        eany;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
    input logic wea, input logic [3:0] waa, input logic [31:0] wda,
    input logic web, input logic [3:0] wab, input logic [31:0] wdb,
    input logic iss, input logic [3:0] ia,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
    input logic [2:0] erdy, input logic eany);
    vec_t v;
    v.ra = {a2, a1, a0};
    v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
    v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
    v.iss = iss; v.ia = ia;
    v.erd = {e2, e1, e0};
    v.erdy = erdy; v.eany = eany;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
    iss_vld = 1'b0; iss_addr = '0;
  endtask

  initial begin
    vec_t e;
    reset = 1'b1;
    ra = '0;
    r15 = 32'h108;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //         a0 a1 a2  weA waA wdA         weB waB wdB    iss ia  e0            e1            e2            rdy     any
    vecs.push_back(mk(0, 1, 2,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h0,        32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(5, 0, 1,   1, 5, 32'h1234,   0, 0, 32'h0,  0, 0, 32'h1234,     32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(5, 0, 1,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h1234,     32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(7, 7, 7,   1, 7, 32'hA,      1, 7, 32'hB,  0, 0, 32'hA,        32'hA,        32'hA,        3'b111, 0));
    vecs.push_back(mk(7, 7, 7,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'hA,        32'hA,        32'hA,        3'b111, 0));
    vecs.push_back(mk(15, 15, 15, 1, 15, 32'h0,    0, 0, 32'h0,  0, 0, 32'h108,      32'h108,      32'h108,      3'b111, 0));
    vecs.push_back(mk(15, 15, 5, 0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h108,      32'h108,      32'h1234,     3'b111, 0));
    vecs.push_back(mk(9, 7, 15,  0, 0, 32'h0,      1, 9, 32'h99, 0, 0, 32'h99,       32'hA,        32'h108,      3'b111, 0));
    vecs.push_back(mk(9, 7, 15,  0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h99,       32'hA,        32'h108,      3'b111, 0));
    vecs.push_back(mk(2, 9, 0,   0, 0, 32'h0,      0, 0, 32'h0,  1, 2, 32'h0,        32'h99,       32'h0,        3'b111, 0));
    vecs.push_back(mk(2, 9, 0,   1, 2, 32'h22,     0, 0, 32'h0,  1, 2, 32'h22,       32'h99,       32'h0,        3'b111, 1));
    vecs.push_back(mk(2, 9, 0,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h22,       32'h99,       32'h0,        3'b110, 1));
    vecs.push_back(mk(2, 2, 2,   1, 2, 32'h33,     0, 0, 32'h0,  0, 0, 32'h33,       32'h33,       32'h33,       3'b111, 1));
    vecs.push_back(mk(2, 2, 2,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h33,       32'h33,       32'h33,       3'b111, 0));
    vecs.push_back(mk(4, 0, 0,   0, 0, 32'h0,      0, 0, 32'h0,  1, 4, 32'h0,        32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(4, 4, 0,   0, 0, 32'h0,      1, 4, 32'h44, 0, 0, 32'h44,       32'h44,       32'h0,        3'b111, 1));
    vecs.push_back(mk(4, 0, 0,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h44,       32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(15, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,  1, 15, 32'h108,     32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(15, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h108,      32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(3, 3, 1,   0, 0, 32'h0,      0, 0, 32'h0,  1, 3, 32'h0,        32'h0,        32'h0,        3'b111, 0));
    vecs.push_back(mk(1, 3, 3,   0, 0, 32'h0,      0, 0, 32'h0,  0, 0, 32'h0,        32'h0,        32'h0,        3'b001, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      ra = vecs[i].ra;
      we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
      we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
      iss_vld = vecs[i].iss; iss_addr = vecs[i].ia;
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_rd", i), {32'h0, rd}, {32'h0, e.erd});
      chk($sformatf("vec%0d_rdy", i), {125'h0, rdy}, {125'h0, e.erdy});
      chk($sformatf("vec%0d_any_pend", i), {127'h0, any_pend}, {127'h0, e.eany});
    end
    @(negedge clk);
    idle_inputs();

    // Reset asserted mid-cycle after writing r3 with r6 pending.
    @(negedge clk);
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hDEADBEEF;
    iss_vld = 1'b1; iss_addr = 4'd6;
    @(negedge clk);
    idle_inputs();
    ra = {4'd6, 4'd0, 4'd3};
    #1;
    chk("pre_reset_r3", {96'h0, rd[31:0]}, {96'h0, 32'hDEADBEEF});
    chk("pre_reset_any", {127'h0, any_pend}, 128'h1);
    reset = 1'b1;
    #1;
    chk("reset_rd", {32'h0, rd}, 128'h0);
    chk("reset_rdy", {125'h0, rdy}, {125'h0, 3'b111});
    chk("reset_any", {127'h0, any_pend}, 128'h0);
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h55;
    @(negedge clk);
    we_a = 1'b0;
    reset = 1'b0;
    #2;
    chk("write_during_reset_dropped", {96'h0, rd[31:0]}, 128'h0);

    // PC read returns r15 whatever value is supplied.
    r15 = 32'h2000;
    ra = {4'd15, 4'd15, 4'd15};
    #1;
    chk("pc_new_r15", {32'h0, rd}, {32'h0, {3{32'h2000}}});

`ifdef REGFILE_BANKED_EN
    @(negedge clk);
    irq_mode = 1'b0; we_a = 1'b1; wa_a = 4'd13; wd_a = 32'h100;
    @(negedge clk);
    irq_mode = 1'b1; wa_a = 4'd13; wd_a = 32'h200;
    @(negedge clk);
    idle_inputs();
    ra = {4'd0, 4'd0, 4'd13};
    #1;
    chk("bank_irq_r13", {96'h0, rd[31:0]}, {96'h0, 32'h200});
    irq_mode = 1'b0;
    #1;
    chk("bank_usr_r13", {96'h0, rd[31:0]}, {96'h0, 32'h100});
    iss_vld = 1'b1; iss_addr = 4'd14; irq_mode = 1'b1;
    @(negedge clk);
    iss_vld = 1'b0;
    ra = {4'd0, 4'd0, 4'd14};
    #1;
    chk("bank_irq_r14_pend", {125'h0, rdy}, {125'h0, 3'b110});
    irq_mode = 1'b0;
    #1;
    chk("bank_usr_r14_ready", {125'h0, rdy}, {125'h0, 3'b111});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
